hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised register-hazard interlock for the decode (ID) stage, replacing the fixed-latency load-to-use and branch-register checks. It keeps a per-register scoreboard of two countdown timers, loaded when a producer leaves ID. The timers track when that producer's result can be forwarded and when it reaches the register file. From these it decides each cycle whether the instruction in ID must stall. This supports multi-cycle units (multiply, variable-latency loads) without per-unit hazard logic, and adds a stall-cause output and a saturating stall-cycle counter.

## Interface
- NREG, 16, number of architectural registers; register 0 is hardwired zero and never tracked
- RW, $clog2(NREG), register index width
- MAX_LAT, 7, largest accepted latency; larger inputs clamp to MAX_LAT
- LW, $clog2(MAX_LAT+1), timer width
- CNT_W, 32, stall-counter width

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- flush  in  1  ID instruction is being squashed this cycle
- id_rs, id_rt  in  RW  source registers
- rs_used, rt_used  in  1  source is read
- rt_is_store_data  in  1  rt is consumed in MEM (store data), not EX
- branch_reg  in  1  rs is consumed in ID with no forwarding
- id_dest  in  RW  destination register
- dest_we  in  1  instruction writes id_dest
- lat_fwd  in  LW  cycles after leaving ID until the result is forwardable into EX (ALU 1, load 2, multiply 4)
- lat_wb  in  LW  cycles after leaving ID until the write-through register-file write (5-stage ALU/load 3)
- stall  out  1  hold ID, insert bubble into EX
- stall_cause  out  2  hazard_pkg cause: NONE, EX_SRC, STORE_DATA, BRANCH_REG (priority BRANCH_REG > EX_SRC > STORE_DATA)
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1

## Operation
- State: rdy[r] and wb[r] (LW bits) for r=1..NREG-1; reads of index 0 return 0.
- The stall conditions (src means id_rs/id_rt when the corresponding *_used is set):
  - EX_SRC: rdy[src] > 1 for rs, or for rt when !rt_is_store_data.
  - STORE_DATA: rt_used & rt_is_store_data & rdy[rt] > 2.
  - BRANCH_REG: branch_reg & wb[rs] > 1.
- stall = id_valid & !flush & (any condition). stall_cause reports NONE when stall=0.
- Issue occurs when id_valid & !stall & !flush & dest_we & id_dest≠0.
- Each cycle, every nonzero timer decrements by 1 (saturating at 0).
- On issue, rdy[id_dest] ← max(rdy[id_dest]−1, clamp(lat_fwd)) and wb[id_dest] ← max(wb[id_dest]−1, clamp(lat_wb)). The max keeps a write-after-write ordering safe. lat=0 leaves the timer only decrementing.
- A consumer and producer in the same instruction (id_dest = id_rs) check old timers, then load new ones.
- On flush, nothing is issued, but in-flight timers keep decrementing (older instructions still complete).
- stall_cycles increments when stall=1, holds at all-ones.

## Timing
- stall and stall_cause are combinational from current inputs and registered timers; there is no registered latency.
- A producer issued in cycle t has rdy=lat_fwd visible at t+1.
- Back-to-back dependents:
  - ALU→ALU: 0 stalls.
  - load→ALU: 1 stall.
  - load→store-data: 0 stalls.
  - lat_fwd=4 multiply→ALU: 3 stalls.
  - ALU (lat_wb=3)→branch_reg: 2 stalls.
- Reset: all timers 0, stall_cycles 0. stall=0 and stall_cause=NONE whenever timers are 0. Reset mid-operation discards all pending timers the same edge.
- A stall outranks issue: a stalled instruction never loads timers until the cycle it proceeds.

## Structure
- hazard_pkg: stall_cause_t enum (NONE=0, EX_SRC=1, STORE_DATA=2, BRANCH_REG=3) and the EX/STORE/BRANCH threshold constants (1, 2, 1).
- One sub-module, hazard_reg_timer: a pair of decrementing timers with the max-load rule. It is instantiated NREG−1 times in a generate loop. The top holds the read muxes, stall logic and counter.

## Test plan
- Reset with rst_n=0 for 2 cycles, any inputs → stall=0, stall_cause=NONE, stall_cycles=0.
- Load r3 (lat_fwd=2, lat_wb=3) at t, then ALU reading rs=r3 at t+1 → stall=1 EX_SRC at t+1 only, proceeds t+2, stall_cycles=1.
- Load r3, then store with rt=r3, rt_is_store_data=1 → no stall. Same with rs=r3 → 1 stall.
- ALU r5 (lat_wb=3), then branch_reg rs=r5 → stall BRANCH_REG for 2 cycles. A source of r0 or a dest of r0 → never stalls.
- Multiply r7 lat_fwd=4, then ALU lat_fwd=1 to r7 one cycle later, then reader of r7 → the reader stalls until the multiply's timer expires (WAW max rule), 2 stalls.
- Stalled consumer with flush=1 in the same cycle → stall=0, no issue, timers keep decrementing. stall_cycles saturates at all-ones with CNT_W=4 after 16+ stall cycles.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and thresholds for the decode-stage register hazard interlock.
package hazard_pkg;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    EX_SRC     = 2'd1,
    STORE_DATA = 2'd2,
    BRANCH_REG = 2'd3
  } stall_cause_t;

  // A source stalls while its timer exceeds the threshold for where it is consumed.
  localparam int unsigned EX_THRESH     = 1;
  localparam int unsigned STORE_THRESH  = 2;
  localparam int unsigned BRANCH_THRESH = 1;

endpackage

// File: rtl/hazard_scoreboard_reg_timer.sv
// Per-register forward/writeback countdown pair; a new producer never shortens a pending timer.
module hazard_reg_timer #(
  parameter int unsigned MAX_LAT = 7,
  parameter int unsigned LW      = $clog2(MAX_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [LW-1:0] lat_fwd,
  input  logic [LW-1:0] lat_wb,
  output logic [LW-1:0] rdy,
  output logic [LW-1:0] wb
);

  function automatic logic [LW-1:0] next_val(input logic [LW-1:0] cur,
                                             input logic [LW-1:0] lat,
                                             input logic          ld);
    logic [LW-1:0] dec;
    logic [LW-1:0] lim;
    dec = (cur == '0) ? '0 : cur - LW'(1);
    // Compare one bit wider so the clamp stays meaningful when MAX_LAT fills LW.
    lim = ({1'b0, lat} > (LW + 1)'(MAX_LAT)) ? LW'(MAX_LAT) : lat;
    if (ld && (lim > dec)) next_val = lim;
    else                   next_val = dec;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy <= '0;
      wb  <= '0;
    end else begin
      rdy <= next_val(rdy, lat_fwd, load);
      wb  <= next_val(wb, lat_wb, load);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage interlock: per-register timers, stall decision with cause, saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREG    = 16,
  parameter int unsigned RW      = $clog2(NREG),
  parameter int unsigned MAX_LAT = 7,
  parameter int unsigned LW      = $clog2(MAX_LAT + 1),
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             flush,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic             rt_is_store_data,
  input  logic             branch_reg,
  input  logic [RW-1:0]    id_dest,
  input  logic             dest_we,
  input  logic [LW-1:0]    lat_fwd,
  input  logic [LW-1:0]    lat_wb,
  output logic             stall,
  output stall_cause_t     stall_cause,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [LW-1:0] rdy [NREG];
  logic [LW-1:0] wb  [NREG];
  logic [LW-1:0] rdy_rs, rdy_rt, wb_rs;
  logic          ex_src, store_data, branch_hz, issue;

  assign rdy[0] = '0;
  assign wb[0]  = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    hazard_reg_timer #(
      .MAX_LAT (MAX_LAT),
      .LW      (LW)
    ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (issue && (id_dest == RW'(r))),
      .lat_fwd (lat_fwd),
      .lat_wb  (lat_wb),
      .rdy     (rdy[r]),
      .wb      (wb[r])
    );
  end

  assign rdy_rs = rdy[id_rs];
  assign rdy_rt = rdy[id_rt];
  assign wb_rs  = wb[id_rs];

  always_comb begin
    ex_src      = (rs_used && (rdy_rs > LW'(EX_THRESH))) ||
                  (rt_used && !rt_is_store_data && (rdy_rt > LW'(EX_THRESH)));
    store_data  = rt_used && rt_is_store_data && (rdy_rt > LW'(STORE_THRESH));
    branch_hz   = branch_reg && (wb_rs > LW'(BRANCH_THRESH));
    stall       = id_valid && !flush && (ex_src || store_data || branch_hz);
    stall_cause = NONE;
    if (stall) begin
      if (branch_hz)   stall_cause = BRANCH_REG;
      else if (ex_src) stall_cause = EX_SRC;
      else             stall_cause = STORE_DATA;
    end
  end

  // Timers are loaded by the old-timer stall decision, so a self-dependent instruction sees its predecessor.
  assign issue = id_valid && !stall && !flush && dest_we && (id_dest != '0);

  always_ff @(posedge clk) begin
    if (!rst_n)                            stall_cycles <= '0;
    else if (stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule
